// File: rtl/sonic_gearbox_pkg.sv
// Shared definitions for the SONIC upstream (40->64) and downstream (64->40) gearboxes.
package sonic_gearbox_pkg;

  localparam int unsigned PMA_WIDTH        = 40;
  localparam int unsigned XGMII_WORD_WIDTH = 64;
  localparam int unsigned GB_FRAME_WORDS   = 8;

  typedef enum logic [0:0] {
    GB_IDLE,
    GB_RUN
  } gb_state_t;

  typedef logic [6:0] fill_t;

endpackage

// File: rtl/sonic_upstream_gearbox.sv
// Receive gearbox: packs the 40-bit PMA stream LSB-first into 64-bit words for the RX FIFO.
// Optional block-sync bit slip is enabled by defining SONIC_UPSTREAM_GEARBOX_SLIP_EN.
module sonic_upstream_gearbox
  import sonic_gearbox_pkg::*;
#(
  parameter int unsigned INPUT_WIDTH  = PMA_WIDTH,
  parameter int unsigned OUTPUT_WIDTH = XGMII_WORD_WIDTH,
  parameter int unsigned BUF_WIDTH    = 104
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_ena,
  input  logic [INPUT_WIDTH-1:0]  i_data_in,
  input  logic                    i_wr_full,
`ifdef SONIC_UPSTREAM_GEARBOX_SLIP_EN
  input  logic                    i_slip,
`endif
  output logic [OUTPUT_WIDTH-1:0] o_data_out,
  output logic                    o_wrreq,
  output logic [2:0]              o_phase,
  output logic                    o_overflow
);

  if (INPUT_WIDTH != 40 || OUTPUT_WIDTH != 64 || BUF_WIDTH != 104) begin : g_param_check
    $error("sonic_upstream_gearbox supports only 40->64 with a 104-bit accumulator");
  end

  gb_state_t               r_state, w_state_next;
  fill_t                   r_fill;
  logic [BUF_WIDTH-1:0]    r_buf;
  logic [2:0]              r_phase;
  logic [OUTPUT_WIDTH-1:0] r_data_out;
  logic                    r_wrreq;
  logic                    r_overflow;

  logic                    w_accept;
  logic                    w_leave;
  logic                    w_slip;
  logic [BUF_WIDTH-1:0]    w_ins;
  logic [BUF_WIDTH-1:0]    w_keep;
  logic [BUF_WIDTH-1:0]    w_buf_next;
  fill_t                   w_add;
  fill_t                   w_sum;
  logic                    w_emit;

`ifdef SONIC_UPSTREAM_GEARBOX_SLIP_EN
  assign w_slip = i_slip;
`else
  assign w_slip = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_leave      = 1'b0;
    unique case (r_state)
      GB_IDLE: begin
        w_accept = i_ena;
        if (i_ena) w_state_next = GB_RUN;
      end
      GB_RUN: begin
        w_accept = i_ena;
        if (!i_ena) begin
          w_state_next = GB_IDLE;
          w_leave      = 1'b1;
        end
      end
      default: w_state_next = GB_IDLE;
    endcase
  end

  // A slip drops data_in[0], so only 39 bits land above the held fill.
  always_comb begin
    w_ins      = BUF_WIDTH'(w_slip ? (i_data_in >> 1) : i_data_in);
    w_add      = w_slip ? fill_t'(INPUT_WIDTH - 1) : fill_t'(INPUT_WIDTH);
    w_sum      = r_fill + w_add;
    w_keep     = ~({BUF_WIDTH{1'b1}} << r_fill);
    w_buf_next = (r_buf & w_keep) | (w_ins << r_fill);
    w_emit     = (w_sum >= fill_t'(OUTPUT_WIDTH));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= GB_IDLE;
      r_fill     <= '0;
      r_buf      <= '0;
      r_phase    <= '0;
      r_data_out <= '0;
      r_wrreq    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      // The sink sees the write on the cycle wrreq is high; full then means a lost word.
      r_overflow <= r_overflow | (r_wrreq & i_wr_full);
      if (w_accept) begin
        r_phase <= r_phase + 3'd1;
        if (w_emit) begin
          r_data_out <= w_buf_next[OUTPUT_WIDTH-1:0];
          r_wrreq    <= 1'b1;
          r_buf      <= w_buf_next >> OUTPUT_WIDTH;
          r_fill     <= w_sum - fill_t'(OUTPUT_WIDTH);
        end else begin
          r_wrreq <= 1'b0;
          r_buf   <= w_buf_next;
          r_fill  <= w_sum;
        end
      end else begin
        r_wrreq <= 1'b0;
        if (w_leave) begin
          r_fill  <= '0;
          r_phase <= '0;
        end
      end
    end
  end

  assign o_data_out = r_data_out;
  assign o_wrreq    = r_wrreq;
  assign o_phase    = r_phase;
  assign o_overflow = r_overflow;

endmodule

// File: tb/tb_sonic_upstream_gearbox.sv
// Bench for sonic_upstream_gearbox: directed scenarios plus random traffic against a bit-queue model.
module tb_sonic_upstream_gearbox;

`ifdef SONIC_UPSTREAM_GEARBOX_SLIP_EN
  localparam bit SlipOn = 1'b1;
`else
  localparam bit SlipOn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ena = 1'b0;
  logic [39:0] din = '0;
  logic        wr_full = 1'b0;
  logic        slip = 1'b0;
  logic [63:0] dout;
  logic        wrreq;
  logic [2:0]  phase;
  logic        ovf;

  int checks = 0;
  int failures = 0;

  // Reference model: a plain LSB-first bit queue, popped 64 bits at a time.
  bit          mq[$];
  logic [63:0] m_dout;
  bit          m_wr;
  int          m_phase;
  bit          m_ovf;

  always #5 clk = ~clk;

  sonic_upstream_gearbox dut (
    .clk        (clk),
    .reset      (reset),
    .i_ena      (ena),
    .i_data_in  (din),
    .i_wr_full  (wr_full),
`ifdef SONIC_UPSTREAM_GEARBOX_SLIP_EN
    .i_slip     (slip),
`endif
    .o_data_out (dout),
    .o_wrreq    (wrreq),
    .o_phase    (phase),
    .o_overflow (ovf)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_dout  = '0;
    m_wr    = 1'b0;
    m_phase = 0;
    m_ovf   = 1'b0;
  endtask

  task automatic step(input bit e, input logic [39:0] d, input bit f, input bit s);
    bit          sl;
    logic [63:0] w;
    ena     = e;
    din     = d;
    wr_full = f;
    slip    = s;
    @(posedge clk);
    sl    = SlipOn && s;
    m_ovf = m_ovf | (m_wr & f);
    if (e) begin
      for (int i = (sl ? 1 : 0); i < 40; i++) mq.push_back(d[i]);
      m_phase = (m_phase + 1) % 8;
      if (mq.size() >= 64) begin
        for (int i = 0; i < 64; i++) w[i] = mq.pop_front();
        m_dout = w;
        m_wr   = 1'b1;
      end else begin
        m_wr = 1'b0;
      end
    end else begin
      mq.delete();
      m_phase = 0;
      m_wr    = 1'b0;
    end
    #1;
    chk("wrreq", wrreq, m_wr);
    chk("data_out", dout, m_dout);
    chk("phase", phase, m_phase);
    chk("overflow", ovf, m_ovf);
  endtask

  function automatic logic [39:0] rnd40();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[39:0];
  endfunction

  initial begin
    logic [63:0]  gold[5];
    logic [319:0] big;
    bit           pat[8];
    logic [63:0]  got[$];
    logic [39:0]  a, b;
    int           nwr;

    gold = '{64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 64'h0,
             64'hFFFFFFFFFFFFFFFF, 64'hA5A5A5A5A5A5A5A5};
    pat  = '{0, 1, 0, 1, 1, 0, 1, 1};
    big  = {gold[4], gold[3], gold[2], gold[1], gold[0]};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_data_out", dout, 64'h0);
    chk("rst_wrreq", wrreq, 0);
    chk("rst_phase", phase, 0);
    chk("rst_overflow", ovf, 0);
    reset = 1'b0;
    model_reset();

    // One frame of the reference split
    for (int k = 0; k < 8; k++) begin
      step(1, big[40*k +: 40], 0, 0);
      chk("t1_wr_pattern", wrreq, pat[k]);
      if (wrreq) got.push_back(dout);
    end
    chk("t1_nwrites", got.size(), 5);
    for (int j = 0; j < got.size() && j < 5; j++) chk("t1_word", got[j], gold[j]);
    chk("t1_phase_end", phase, 0);
    chk("t1_fill_end", dut.r_fill, 0);

    // Three continuous frames
    nwr = 0;
    for (int k = 0; k < 24; k++) begin
      step(1, rnd40(), 0, 0);
      chk("t2_wr_pattern", wrreq, pat[k % 8]);
      nwr += int'(wrreq);
    end
    chk("t2_nwrites", nwr, 15);

    // Drop ena with 56 bits pending, then a fresh frame
    for (int k = 0; k < 3; k++) step(1, rnd40(), 0, 0);
    chk("t3_fill56", dut.r_fill, 56);
    for (int k = 0; k < 3; k++) begin
      step(0, rnd40(), 0, 0);
      chk("t3_no_partial_write", wrreq, 0);
    end
    a = rnd40();
    b = rnd40();
    step(1, a, 0, 0);
    step(1, b, 0, 0);
    chk("t3_first_wr", wrreq, 1);
    chk("t3_first_word", dout, {b[23:0], a});

    // Asynchronous reset mid-frame at phase 3
    step(1, rnd40(), 0, 0);
    chk("t4_at_phase3", phase, 3);
    #2 reset = 1'b1;
    #1;
    chk("t4_async_data_out", dout, 64'h0);
    chk("t4_async_wrreq", wrreq, 0);
    chk("t4_async_phase", phase, 0);
    chk("t4_async_fill", dut.r_fill, 0);
    ena = 1'b0;
    @(negedge clk);
    chk("t4_held_wrreq", wrreq, 0);
    reset = 1'b0;
    model_reset();
    for (int k = 0; k < 8; k++) begin
      step(1, rnd40(), 0, 0);
      chk("t4_realign_pattern", wrreq, pat[k]);
    end
    chk("t4_fill_end", dut.r_fill, 0);

    // Sink full while the phase-3 word is being written
    for (int k = 0; k < 8; k++) begin
      step(1, rnd40(), k == 4, 0);
      if (k == 4) begin
        chk("t5_wr_pulse_while_full", wrreq, 1);
        chk("t5_ovf_set", ovf, 1);
      end
    end
    chk("t5_ovf_sticky", ovf, 1);

`ifdef SONIC_UPSTREAM_GEARBOX_SLIP_EN
    // Single slip on an all-ones stream whose first bit is zero
    step(0, '0, 0, 0);
    step(1, 40'hFFFFFFFFFE, 0, 1);
    nwr = 0;
    for (int k = 0; k < 15; k++) begin
      step(1, 40'hFFFFFFFFFF, 0, 0);
      if (wrreq) begin
        nwr++;
        chk("t6_slip_all_ones", dout, 64'hFFFFFFFFFFFFFFFF);
      end
    end
    chk("t6_slip_nwrites", nwr, 9);
`endif

    // Random traffic with ena gaps, sink-full and slips
    for (int k = 0; k < 200; k++) begin
      step($urandom_range(0, 9) != 0, rnd40(), $urandom_range(0, 3) == 0,
           SlipOn && ($urandom_range(0, 4) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
